// File: rtl/mac_lane_array.sv
`default_nettype none
// ============================================================================
// Module      : mac_lane_array
// Description : Pipelined multi-lane multiply-accumulate unit. Each accepted
//               beat carries LANES unsigned-activation x signed-weight pairs.
//               The products are summed across lanes and accumulated over a
//               group of beats closed by in_last. The group total is rounded,
//               arithmetically shifted right by a runtime scale, saturated and
//               presented on a valid/ready output.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_lane_array #(
  parameter int LANES       = 4,
  parameter int A_WIDTH     = 8,
  parameter int B_WIDTH     = 8,
  parameter int ACC_WIDTH   = 32,
  parameter int OUT_WIDTH   = 16,
  parameter int SCALE_WIDTH = 5
) (
  input  logic                         clk,
  input  logic                         arst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_last,
  input  logic [LANES*A_WIDTH-1:0]     a,
  input  logic [LANES*B_WIDTH-1:0]     b,
  input  logic [SCALE_WIDTH-1:0]       scale,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [OUT_WIDTH-1:0]  out,
  output logic                         out_sat
);

  // Exact width of one lane product: (A_WIDTH+1)-bit signed x B_WIDTH signed.
  localparam int PROD_W = A_WIDTH + B_WIDTH + 1;
  // One guard bit so that adding the rounding constant can never overflow.
  localparam int EXT_W  = ACC_WIDTH + 1;

  localparam logic signed [EXT_W-1:0] SAT_MAX =
    {{(EXT_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] SAT_MIN =
    {{(EXT_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  logic stall;
  logic accept;

  // Lane products, sign-extended to accumulator width
  logic signed [ACC_WIDTH-1:0] lane_prod [LANES];

  // P1 stage
  logic                        p1_valid;
  logic                        p1_last;
  logic [SCALE_WIDTH-1:0]      p1_scale;
  logic signed [ACC_WIDTH-1:0] p1_prod [LANES];

  // P2 stage
  logic                        p2_valid;
  logic                        p2_last;
  logic [SCALE_WIDTH-1:0]      p2_scale;
  logic signed [ACC_WIDTH-1:0] p2_sum;

  // Accumulator and result path
  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] lane_sum;
  logic signed [ACC_WIDTH-1:0] total;
  logic signed [EXT_W-1:0]     ext;
  logic signed [EXT_W-1:0]     rnd;
  logic signed [EXT_W-1:0]     shifted;
  logic signed [OUT_WIDTH-1:0] sat_val;
  logic                        sat_flag;

  // A pending result that downstream refuses freezes the whole pipeline.
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;
  assign accept   = in_valid & in_ready;

  generate
    for (genvar i = 0; i < LANES; i++) begin : g_lane
      logic signed [A_WIDTH:0]   a_s;
      logic signed [B_WIDTH-1:0] b_s;
      logic signed [PROD_W-1:0]  prod;

      // Activation gets a zero sign bit so it multiplies as a signed value.
      assign a_s  = {1'b0, a[i*A_WIDTH +: A_WIDTH]};
      assign b_s  = b[i*B_WIDTH +: B_WIDTH];
      assign prod = PROD_W'(a_s) * PROD_W'(b_s);
      assign lane_prod[i] = ACC_WIDTH'(prod);
    end
  endgenerate

  // P1: capture lane products and beat sideband on accepted beats
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      p1_valid <= 1'b0;
      p1_last  <= 1'b0;
      p1_scale <= '0;
      for (int i = 0; i < LANES; i++) p1_prod[i] <= '0;
    end else if (!stall) begin
      p1_valid <= accept;
      if (accept) begin
        p1_last  <= in_last;
        p1_scale <= scale;
        for (int i = 0; i < LANES; i++) p1_prod[i] <= lane_prod[i];
      end
    end
  end

  // Cross-lane sum of the registered products
  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < LANES; i++) lane_sum = lane_sum + p1_prod[i];
  end

  // P2: register the lane sum with its sideband
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      p2_valid <= 1'b0;
      p2_last  <= 1'b0;
      p2_scale <= '0;
      p2_sum   <= '0;
    end else if (!stall) begin
      p2_valid <= p1_valid;
      if (p1_valid) begin
        p2_last  <= p1_last;
        p2_scale <= p1_scale;
        p2_sum   <= lane_sum;
      end
    end
  end

  // Group total, rounding shift (half toward +inf) and output clamp
  always_comb begin
    total    = acc + p2_sum;
    ext      = {total[ACC_WIDTH-1], total};
    rnd      = EXT_W'(1) << (p2_scale - SCALE_WIDTH'(1));
    shifted  = ext;
    sat_flag = 1'b0;
    sat_val  = '0;
    if (p2_scale != '0) shifted = (ext + rnd) >>> p2_scale;
    if (shifted > SAT_MAX) begin
      sat_val  = SAT_MAX[OUT_WIDTH-1:0];
      sat_flag = 1'b1;
    end else if (shifted < SAT_MIN) begin
      sat_val  = SAT_MIN[OUT_WIDTH-1:0];
      sat_flag = 1'b1;
    end else begin
      sat_val  = shifted[OUT_WIDTH-1:0];
    end
  end

  // Accumulate; on the last beat clear acc and load the output register
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      acc       <= '0;
      out_valid <= 1'b0;
      out       <= '0;
      out_sat   <= 1'b0;
    end else if (!stall) begin
      // Not stalled means any held result is being consumed this edge.
      out_valid <= 1'b0;
      if (p2_valid) begin
        if (p2_last) begin
          acc       <= '0;
          out       <= sat_val;
          out_sat   <= sat_flag;
          out_valid <= 1'b1;
        end else begin
          acc <= total;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mac_lane_array.sv
`default_nettype none
// ============================================================================
// Module      : tb_mac_lane_array
// Description : Self-checking bench for mac_lane_array: directed single-beat
//               vectors from a table, plus hand sequences for multi-beat
//               groups, backpressure streaming and reset mid-group.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_lane_array;

  logic               clk;
  logic               arst;
  logic               in_valid;
  logic               in_ready;
  logic               in_last;
  logic [31:0]        a;
  logic [31:0]        b;
  logic [4:0]         scale;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] out;
  logic               out_sat;

  int checks = 0;
  int errors = 0;

  mac_lane_array #(
    .LANES(4), .A_WIDTH(8), .B_WIDTH(8), .ACC_WIDTH(32), .OUT_WIDTH(16), .SCALE_WIDTH(5)
  ) dut (
    .clk(clk), .arst(arst), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .a(a), .b(b), .scale(scale), .out_valid(out_valid),
    .out_ready(out_ready), .out(out), .out_sat(out_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] av;
    logic [31:0] bv;
    logic [4:0]  sc;
    int          exp_out;
    int          exp_sat;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Present one beat at the current negedge; returns at the following negedge.
  task automatic send_beat(input logic [31:0] av, input logic [31:0] bv,
                           input logic lst, input logic [4:0] sc);
    a = av; b = bv; in_last = lst; scale = sc; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Called at the negedge after the last beat's accepting edge.
  task automatic wait_result(input string nm, input int exp, input int exp_sat);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_latency"}, n, 2);
    check({nm, "_out"}, $signed(out), exp);
    check({nm, "_sat"}, out_sat, exp_sat);
  endtask

  initial begin
    int idx, ridx, first_hs, last_hs, extra;
    bit acc_now;

    vecs[0]  = '{"ones_sum10",  32'h04030201, 32'h01010101, 5'd0,  10,     0};
    vecs[1]  = '{"neg_sat",     32'hffffffff, 32'h80808080, 5'd0,  -32768, 1};
    vecs[2]  = '{"pos_sat",     32'hffffffff, 32'h7f7f7f7f, 5'd0,  32767,  1};
    vecs[3]  = '{"rnd_6_s2",    32'h00000006, 32'h00000001, 5'd2,  2,      0};
    vecs[4]  = '{"rnd_m6_s2",   32'h00000006, 32'h000000ff, 5'd2,  -1,     0};
    vecs[5]  = '{"rnd_5_s1",    32'h00000005, 32'h00000001, 5'd1,  3,      0};
    vecs[6]  = '{"rnd_m5_s1",   32'h00000005, 32'h000000ff, 5'd1,  -2,     0};
    vecs[7]  = '{"rnd_m2_s2",   32'h00000002, 32'h000000ff, 5'd2,  0,      0};
    vecs[8]  = '{"mixed_100",   32'h281e140a, 32'h04fd02ff, 5'd0,  100,    0};
    vecs[9]  = '{"neg_300",     32'h00000064, 32'h000000fd, 5'd0,  -300,   0};
    vecs[10] = '{"big_s3",      32'hffffffff, 32'h7f7f7f7f, 5'd3,  16193,  0};
    vecs[11] = '{"neg_s1_sat",  32'hffffffff, 32'h80808080, 5'd1,  -32768, 1};

    arst = 1'b1; in_valid = 1'b0; in_last = 1'b0; a = '0; b = '0; scale = '0;
    out_ready = 1'b1;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_out", $signed(out), 0);
    check("rst_out_sat", out_sat, 0);
    check("rst_in_ready", in_ready, 1);
    @(negedge clk);
    arst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_out_valid", out_valid, 0);

    // Table of single-beat groups
    for (int i = 0; i < 12; i++) begin
      send_beat(vecs[i].av, vecs[i].bv, 1'b1, vecs[i].sc);
      wait_result(vecs[i].name, vecs[i].exp_out, vecs[i].exp_sat);
    end

    // Multi-beat group with idle gap; non-last scale must be ignored
    send_beat(32'h0a0a0a0a, 32'h01010101, 1'b0, 5'd7);
    @(negedge clk);
    @(negedge clk);
    send_beat(32'h0a0a0a0a, 32'h01010101, 1'b0, 5'd3);
    send_beat(32'h0a0a0a0a, 32'h01010101, 1'b1, 5'd0);
    wait_result("multi_120", 120, 0);
    send_beat(32'h01010101, 32'h01010101, 1'b1, 5'd0);
    wait_result("after_group_4", 4, 0);

    // Backpressure then streaming release: results 11..16 in order
    idx = 0; ridx = 0; first_hs = -1; last_hs = -1;
    for (int cyc = 0; cyc < 60 && ridx < 6; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= 8);
      if (idx < 6) begin
        in_valid = 1'b1; in_last = 1'b1; scale = '0;
        a = 32'(11 + idx); b = 32'h01010101;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      acc_now = in_valid && in_ready;
      if (out_valid && !out_ready) begin
        check("stall_in_ready", in_ready, 0);
        check("stall_out_hold", $signed(out), 11);
      end
      if (out_valid && out_ready) begin
        check("stream_out", $signed(out), 11 + ridx);
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
        ridx++;
      end
      @(posedge clk);
      if (acc_now) idx++;
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    check("stream_count", ridx, 6);
    check("stream_no_gaps", last_hs - first_hs, 5);

    // Reset mid-group discards the partial accumulation
    send_beat(32'h0a0a0a0a, 32'h01010101, 1'b0, 5'd0);
    send_beat(32'h0a0a0a0a, 32'h01010101, 1'b0, 5'd0);
    #2 arst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    @(negedge clk);
    arst = 1'b0;
    send_beat(32'h00000007, 32'h01010101, 1'b1, 5'd0);
    wait_result("after_rst_7", 7, 0);
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    check("no_stale_result", extra, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
